mem_write_checker: RTL and testbench
====================================

Name: mem_write_checker

Overview:
- Synthesisable checker on the processor's data-memory write port (memwrite/dataadr/writedata). It is the consumer side of that interface.
- Holds a loadable table of expected (address, data) writes. Once armed, it compares each observed store, in order, against the table and reports pass/fail.
- Lets the single-cycle core regression programs (jr/jal/branch tests) self-check in hardware or on a board, without a behavioural bench.

Parameters:
- DEPTH, 8: number of expected-write table entries (power of 2).
- IDXW, 3: index width, log2(DEPTH).
- TIMEOUT, 1024: cycles allowed from start to completion before timeout failure.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- memwrite  input  1  processor store strobe; one store per cycle when high.
- dataadr  input  32  processor store address.
- writedata  input  32  processor store data.
- exp_we  input  1  table write enable (honoured only in IDLE).
- exp_idx  input  IDXW  table entry index.
- exp_adr  input  32  expected address for entry exp_idx.
- exp_data  input  32  expected data for entry exp_idx.
- exp_count  input  IDXW+1  number of valid entries, 0..DEPTH; sampled at start.
- ign_en  input  1  enable the ignore-address filter.
- ign_adr  input  32  stores to this address are skipped when ign_en=1.
- start  input  1  one-cycle arm pulse.
- done  output  1  check finished (pass or fail); sticky.
- pass  output  1  all expected writes matched.
- fail  output  1  mismatch or timeout.
- timeout  output  1  failure cause was timeout.
- fail_idx  output  IDXW  entry index at failure.
- got_adr  output  32  offending store address (0 on timeout).
- got_data  output  32  offending store data (0 on timeout).
- match_cnt  output  IDXW+1  entries matched so far.

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0. Timer and index 0. Table contents are undefined; the table is not reset.
- States: IDLE, CHECK, PASS, FAIL. All outputs are registered and update on posedge clk.
- IDLE:
  - exp_we=1 writes table[exp_idx] <= {exp_adr, exp_data}.
  - start=1: latch exp_count, clear idx/timer/match_cnt/flags, go to CHECK.
  - If the latched count is 0, go straight to PASS on that edge instead.
- CHECK, each cycle:
  - memwrite=1, ign_en=1 and dataadr==ign_adr: store ignored; idx unchanged.
  - Otherwise, memwrite=1: compare dataadr and writedata against table[idx] (full 32-bit equality, both fields).
    - Match: idx++ and match_cnt++. If the new match_cnt equals the latched count, go to PASS.
    - Mismatch: go to FAIL. Set fail_idx=idx, got_adr=dataadr, got_data=writedata.
  - timer++ every CHECK cycle. When timer reaches TIMEOUT-1 with no completion on that edge, go to FAIL with timeout=1 and fail_idx=idx.
  - A match completion on the same edge as timer expiry wins: PASS.
  - exp_we and start are ignored while in CHECK.
- PASS/FAIL:
  - done=1, with pass or fail =1. Outputs hold.
  - Further memwrite activity is ignored.
  - start re-arms (same rules as from IDLE). exp_we is ignored.
- Latency: a store presented in cycle N is reflected in done/pass/fail/match_cnt after the posedge ending cycle N, i.e. visible in cycle N+1.
- Reset asserted mid-CHECK: immediate return to IDLE, all outputs 0. The table must be reloaded only if the contents are required.
- Exactly one of pass/fail is high when done=1. Neither is high when done=0.

Test Plan:
- Pass case:
  - Load entry0=(0x8, 0xC), exp_count=1, start. Drive stores (0x8, 0xC).
  - Required: pass=1, done=1, match_cnt=1 one cycle after the store.
- Mismatch (jr-skipped-path failure):
  - Same table. Drive store (0x8, 0x10).
  - Required: fail=1, timeout=0, fail_idx=0, got_adr=0x8, got_data=0x10.
- Ignore filter:
  - ign_en=1, ign_adr=0x50. Table entry0=(0x8, 0xC), entry1=(0x4, 0x7), count=2.
  - Drive stores (0x50, 0x1), (0x8, 0xC), (0x50, 0x2), (0x4, 0x7).
  - Required: pass after the fourth store, match_cnt=2.
- Timeout with boundary win:
  - Part 1: TIMEOUT=16, count=1, no stores. Required: fail=1, timeout=1, fail_idx=0, 16 cycles after start.
  - Part 2: a matching store in the 16th cycle. Required: pass=1 instead.
- Edge cases:
  - exp_count=0 plus start. Required: pass=1 next cycle.
  - start pulsed mid-CHECK. Required: no restart (match_cnt keeps counting).
  - exp_we mid-CHECK. Required: no table change.
- Async reset:
  - Assert reset=0 mid-CHECK between clock edges, after 1 of 2 matches.
  - Required: all outputs 0 immediately, without waiting for an edge.
  - Release reset, then start with the same table: a full correct 2-store sequence passes.

Source files
------------

// File: rtl/mem_write_checker.sv
`default_nettype none
// ============================================================================
// Module   : mem_write_checker
// Function : Checks processor data-memory stores, in order, against a
//            loadable table of expected (address, data) pairs.
// Revision : 1.0  initial release
// ============================================================================
module mem_write_checker #(
    parameter int DEPTH   = 8,
    parameter int IDXW    = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [31:0]       dataadr,
    input  logic [31:0]       writedata,
    input  logic              exp_we,
    input  logic [IDXW-1:0]   exp_idx,
    input  logic [31:0]       exp_adr,
    input  logic [31:0]       exp_data,
    input  logic [IDXW:0]     exp_count,
    input  logic              ign_en,
    input  logic [31:0]       ign_adr,
    input  logic              start,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [IDXW-1:0]   fail_idx,
    output logic [31:0]       got_adr,
    output logic [31:0]       got_data,
    output logic [IDXW:0]     match_cnt
);

    localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_PASS  = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW:0]     count_q, count_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [c_TW-1:0]   timer_q, timer_d;
    logic [IDXW:0]     match_cnt_q, match_cnt_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic [IDXW-1:0]   fail_idx_q, fail_idx_d;
    logic [31:0]       got_adr_q, got_adr_d;
    logic [31:0]       got_data_q, got_data_d;

    // Expected-write table: {address, data}; deliberately not reset.
    logic [63:0]       tbl_q [DEPTH];

    logic              w_tbl_we;
    logic [63:0]       w_entry;
    logic              w_ignored;
    logic              w_hit;
    logic [IDXW:0]     w_match_next;

    assign w_tbl_we     = exp_we && (state_q == S_IDLE);
    assign w_entry      = tbl_q[idx_q];
    assign w_ignored    = ign_en && (dataadr == ign_adr);
    assign w_hit        = (dataadr == w_entry[63:32]) && (writedata == w_entry[31:0]);
    assign w_match_next = match_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (w_tbl_we) begin
            tbl_q[exp_idx] <= {exp_adr, exp_data};
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        match_cnt_d = match_cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        fail_idx_d  = fail_idx_q;
        got_adr_d   = got_adr_q;
        got_data_d  = got_data_q;

        case (state_q)
            S_CHECK: begin
                timer_d = timer_q + 1'b1;
                if (memwrite && !w_ignored) begin
                    if (w_hit) begin
                        idx_d       = idx_q + 1'b1;
                        match_cnt_d = w_match_next;
                        if (w_match_next == count_q) begin
                            state_d = S_PASS;
                            done_d  = 1'b1;
                            pass_d  = 1'b1;
                        end
                    end else begin
                        state_d    = S_FAIL;
                        done_d     = 1'b1;
                        fail_d     = 1'b1;
                        fail_idx_d = idx_q;
                        got_adr_d  = dataadr;
                        got_data_d = writedata;
                    end
                end
                // Expiry only applies when the store on this edge did not finish the run.
                if ((state_d == S_CHECK) && (timer_q == c_TMAX)) begin
                    state_d    = S_FAIL;
                    done_d     = 1'b1;
                    fail_d     = 1'b1;
                    timeout_d  = 1'b1;
                    fail_idx_d = idx_q;
                end
            end
            default: begin
                // IDLE, PASS and FAIL all re-arm the same way.
                if (start) begin
                    count_d     = exp_count;
                    idx_d       = '0;
                    timer_d     = '0;
                    match_cnt_d = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    timeout_d   = 1'b0;
                    fail_idx_d  = '0;
                    got_adr_d   = '0;
                    got_data_d  = '0;
                    if (exp_count == '0) begin
                        state_d = S_PASS;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            match_cnt_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_idx_q  <= '0;
            got_adr_q   <= '0;
            got_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            match_cnt_q <= match_cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            fail_idx_q  <= fail_idx_d;
            got_adr_q   <= got_adr_d;
            got_data_q  <= got_data_d;
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign fail_idx  = fail_idx_q;
    assign got_adr   = got_adr_q;
    assign got_data  = got_data_q;
    assign match_cnt = match_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_write_checker
// Function : Directed self-checking bench for mem_write_checker with a
//            queue-based reference model compared on every falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_write_checker;

    localparam int DEPTH   = 8;
    localparam int IDXW    = 3;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              memwrite = 1'b0;
    logic [31:0]       dataadr = '0;
    logic [31:0]       writedata = '0;
    logic              exp_we = 1'b0;
    logic [IDXW-1:0]   exp_idx = '0;
    logic [31:0]       exp_adr = '0;
    logic [31:0]       exp_data = '0;
    logic [IDXW:0]     exp_count = '0;
    logic              ign_en = 1'b0;
    logic [31:0]       ign_adr = '0;
    logic              start = 1'b0;
    logic              done, pass, fail, timeout;
    logic [IDXW-1:0]   fail_idx;
    logic [31:0]       got_adr, got_data;
    logic [IDXW:0]     match_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    mem_write_checker #(.DEPTH(DEPTH), .IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_adr(exp_adr), .exp_data(exp_data), .exp_count(exp_count),
        .ign_en(ign_en), .ign_adr(ign_adr), .start(start), .done(done),
        .pass(pass), .fail(fail), .timeout(timeout), .fail_idx(fail_idx),
        .got_adr(got_adr), .got_data(got_data), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a snapshot queue of outstanding expected stores,
    // a count of elapsed checking cycles, and the resulting verdict.
    logic [63:0] m_tbl [DEPTH];
    logic [63:0] m_q [$];
    bit          m_checking;
    int          m_elapsed;
    int          m_matched;
    bit          m_done, m_pass, m_fail, m_timeout;
    int          m_fail_idx;
    logic [31:0] m_got_adr, m_got_data;
    bit          m_ever_armed;

    task automatic m_clear();
        m_done = 0; m_pass = 0; m_fail = 0; m_timeout = 0;
        m_fail_idx = 0; m_got_adr = '0; m_got_data = '0; m_matched = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_clear();
            m_checking = 0; m_elapsed = 0; m_ever_armed = 0;
            m_q.delete();
        end else if (!m_checking) begin
            if (!m_ever_armed && exp_we) m_tbl[exp_idx] = {exp_adr, exp_data};
            if (start) begin
                m_clear();
                m_ever_armed = 1;
                m_q.delete();
                for (int i = 0; i < int'(exp_count); i++) m_q.push_back(m_tbl[i]);
                m_elapsed = 0;
                if (m_q.size() == 0) begin m_done = 1; m_pass = 1; end
                else m_checking = 1;
            end
        end else begin
            m_elapsed++;
            if (memwrite && !(ign_en && dataadr == ign_adr)) begin
                if (m_q.size() > 0 && {dataadr, writedata} == m_q[0]) begin
                    void'(m_q.pop_front());
                    m_matched++;
                    if (m_q.size() == 0) begin m_checking = 0; m_done = 1; m_pass = 1; end
                end else begin
                    m_checking = 0; m_done = 1; m_fail = 1;
                    m_fail_idx = m_matched; m_got_adr = dataadr; m_got_data = writedata;
                end
            end
            if (m_checking && m_elapsed == TIMEOUT) begin
                m_checking = 0; m_done = 1; m_fail = 1; m_timeout = 1;
                m_fail_idx = m_matched;
            end
        end
    end

    // The table is writable only before the first arm after a reset.
    always @(negedge clk) begin
        if ($time > 0) begin
            check("done",      32'(done),      32'(m_done));
            check("pass",      32'(pass),      32'(m_pass));
            check("fail",      32'(fail),      32'(m_fail));
            check("timeout",   32'(timeout),   32'(m_timeout));
            check("fail_idx",  32'(fail_idx),  32'(m_fail_idx));
            check("got_adr",   got_adr,        m_got_adr);
            check("got_data",  got_data,       m_got_data);
            check("match_cnt", 32'(match_cnt), 32'(m_matched));
        end
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
    endtask

    task automatic load(input int idx, input logic [31:0] adr, input logic [31:0] dat);
        exp_we = 1'b1; exp_idx = IDXW'(idx); exp_adr = adr; exp_data = dat;
        cycle();
        exp_we = 1'b0;
    endtask

    task automatic arm(input int cnt);
        exp_count = (IDXW+1)'(cnt); start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] dat);
        memwrite = 1'b1; dataadr = adr; writedata = dat;
        cycle();
        memwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (2) cycle();
        check("reset_done", 32'(done), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        check("reset_match", 32'(match_cnt), 32'd0);
        reset = 1'b1;
        cycle();

        // Pass case
        load(0, 32'h8, 32'hC);
        arm(1);
        store(32'h8, 32'hC);
        check("pass_pass", 32'(pass), 32'd1);
        check("pass_done", 32'(done), 32'd1);
        check("pass_match", 32'(match_cnt), 32'd1);

        // Mismatch, re-armed from PASS with the same table
        arm(1);
        store(32'h8, 32'h10);
        check("mm_fail", 32'(fail), 32'd1);
        check("mm_timeout", 32'(timeout), 32'd0);
        check("mm_fail_idx", 32'(fail_idx), 32'd0);
        check("mm_got_adr", got_adr, 32'h8);
        check("mm_got_data", got_data, 32'h10);

        // Ignore filter
        do_reset();
        load(0, 32'h8, 32'hC);
        load(1, 32'h4, 32'h7);
        ign_en = 1'b1; ign_adr = 32'h50;
        arm(2);
        store(32'h50, 32'h1);
        store(32'h8, 32'hC);
        check("ign_mid_match", 32'(match_cnt), 32'd1);
        store(32'h50, 32'h2);
        check("ign_mid_done", 32'(done), 32'd0);
        store(32'h4, 32'h7);
        check("ign_pass", 32'(pass), 32'd1);
        check("ign_match", 32'(match_cnt), 32'd2);
        ign_en = 1'b0;

        // Timeout: no stores for TIMEOUT cycles
        arm(1);
        repeat (TIMEOUT - 1) cycle();
        check("to_not_yet", 32'(done), 32'd0);
        cycle();
        check("to_fail", 32'(fail), 32'd1);
        check("to_timeout", 32'(timeout), 32'd1);
        check("to_fail_idx", 32'(fail_idx), 32'd0);
        check("to_got_adr", got_adr, 32'h0);

        // Matching store in the final allowed cycle wins
        arm(1);
        repeat (TIMEOUT - 1) cycle();
        store(32'h8, 32'hC);
        check("to_win_pass", 32'(pass), 32'd1);
        check("to_win_timeout", 32'(timeout), 32'd0);

        // Zero-entry arm
        arm(0);
        check("zero_pass", 32'(pass), 32'd1);
        check("zero_match", 32'(match_cnt), 32'd0);

        // start and exp_we mid-CHECK are ignored
        arm(2);
        store(32'h8, 32'hC);
        start = 1'b1; exp_count = 1;
        exp_we = 1'b1; exp_idx = 1; exp_adr = 32'h99; exp_data = 32'h99;
        cycle();
        start = 1'b0; exp_we = 1'b0;
        check("midstart_match", 32'(match_cnt), 32'd1);
        check("midstart_done", 32'(done), 32'd0);
        store(32'h4, 32'h7);
        check("midwe_pass", 32'(pass), 32'd1);
        check("midwe_match", 32'(match_cnt), 32'd2);

        // Asynchronous reset mid-CHECK
        arm(2);
        store(32'h8, 32'hC);
        #2 reset = 1'b0;
        #1;
        check("arst_match", 32'(match_cnt), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_fail", 32'(fail), 32'd0);
        cycle();
        reset = 1'b1;
        cycle();
        arm(2);
        store(32'h8, 32'hC);
        store(32'h4, 32'h7);
        check("arst_rerun_pass", 32'(pass), 32'd1);
        check("arst_rerun_match", 32'(match_cnt), 32'd2);

        // Stores after completion are ignored
        store(32'h1, 32'h2);
        check("post_pass_hold", 32'(pass), 32'd1);

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
